// File: rtl/s_des_pkg.sv
// S-DES key schedule shared definitions: permutation tables, half-rotate,
// FSM state encoding and key widths.
package s_des_pkg;

    localparam int KEY_W    = 10;
    localparam int SUBKEY_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT1 = 2'd1,
        SHIFT2 = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Positions 1..N with 1 = MSB; entry i names the source position of output i.
    localparam int P10_TAB [10] = '{3, 5, 2, 7, 4, 10, 1, 9, 8, 6};
    localparam int P8_TAB  [8]  = '{6, 3, 7, 4, 8, 5, 10, 9};

    // P10 on a 10-bit key (bit 9 = position 1).
    function automatic logic [KEY_W-1:0] p10(input logic [KEY_W-1:0] k);
        logic [KEY_W-1:0] r;
        r = '0;
        for (int i = 0; i < 10; i++) begin
            r[9-i] = k[10-P10_TAB[i]];
        end
        return r;
    endfunction

    // P8 selects 8 of the 10 positions into a subkey (bit 7 = position 1).
    function automatic logic [SUBKEY_W-1:0] p8(input logic [KEY_W-1:0] k);
        logic [SUBKEY_W-1:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            r[7-i] = k[10-P8_TAB[i]];
        end
        return r;
    endfunction

    // Rotate a 5-bit half left by n (n in 0..4).
    function automatic logic [4:0] rol5(input logic [4:0] x, input int n);
        logic [9:0] d;
        d = {x, x};
        return d[9-n -: 5];
    endfunction

    // LS-n: rotate each half of the 10-bit key independently.
    function automatic logic [KEY_W-1:0] ls(input logic [KEY_W-1:0] k, input int n);
        return {rol5(k[9:5], n), rol5(k[4:0], n)};
    endfunction

endpackage

// File: rtl/s_des_key_sched.sv
// Sequential S-DES key schedule. Derives K1 and K2 from a 10-bit master key
// over two cycles after accept and presents them in round order.
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both 1; req_valid seen while req_ready is 0 is ignored, so
// the upstream stage holds it until it is taken.
module s_des_key_sched
    import s_des_pkg::*;
#(
    parameter bit OUT_PIPE = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [KEY_W-1:0]    key_in,
    input  logic                decrypt,
    output logic [SUBKEY_W-1:0] k_first,
    output logic [SUBKEY_W-1:0] k_second,
    output logic                keys_valid,
    output logic                busy
);

    state_t              state, state_nxt;
    logic [KEY_W-1:0]    kreg;
    logic                mode;
    logic [SUBKEY_W-1:0] k1;
    logic [SUBKEY_W-1:0] k_first_c, k_second_c;
    logic                valid_c;
    logic                accept;
    logic [KEY_W-1:0]    kreg_ls1, kreg_ls2;
    logic [SUBKEY_W-1:0] k2_nxt;

    assign accept   = req_valid & req_ready;
    assign kreg_ls1 = ls(kreg, 1);
    assign kreg_ls2 = ls(kreg, 2);
    assign k2_nxt   = p8(kreg_ls2);
    assign valid_c  = (state == DONE);

    // In DONE readiness follows the visible keys_valid, so with the output
    // pipe a new request waits until the previous result has been shown.
    assign req_ready = (state == IDLE) | ((state == DONE) & keys_valid);
    assign busy      = (state == SHIFT1) | (state == SHIFT2);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = SHIFT1;
            SHIFT1:  state_nxt = SHIFT2;
            SHIFT2:  state_nxt = DONE;
            DONE:    if (accept) state_nxt = SHIFT1;
            default: state_nxt = IDLE;
        endcase
    end

    // Key datapath. K2 is never stored on its own: it goes straight into the
    // ordered output registers, which only change on the SHIFT2 -> DONE edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            kreg       <= '0;
            mode       <= 1'b0;
            k1         <= '0;
            k_first_c  <= '0;
            k_second_c <= '0;
        end else if (accept) begin
            kreg <= p10(key_in);
            mode <= decrypt;
        end else begin
            case (state)
                SHIFT1: begin
                    kreg <= kreg_ls1;
                    k1   <= p8(kreg_ls1);
                end
                SHIFT2: begin
                    kreg       <= kreg_ls2;
                    k_first_c  <= mode ? k2_nxt : k1;
                    k_second_c <= mode ? k1 : k2_nxt;
                end
                default: ;
            endcase
        end
    end

    generate
        if (OUT_PIPE) begin : g_pipe
            logic                valid_q;
            logic [SUBKEY_W-1:0] k_first_q, k_second_q;

            // Extra output stage; valid clears on the accepting edge so it is
            // never seen high while a new derivation runs.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    valid_q    <= 1'b0;
                    k_first_q  <= '0;
                    k_second_q <= '0;
                end else begin
                    valid_q    <= valid_c & ~accept;
                    k_first_q  <= k_first_c;
                    k_second_q <= k_second_c;
                end
            end

            assign keys_valid = valid_q;
            assign k_first    = k_first_q;
            assign k_second   = k_second_q;
        end else begin : g_direct
            assign keys_valid = valid_c;
            assign k_first    = k_first_c;
            assign k_second   = k_second_c;
        end
    endgenerate

endmodule

// File: tb/tb_s_des_key_sched.sv
// Directed bench for s_des_key_sched: one instance without and one with the
// output pipe, checked against hand-computed S-DES subkeys.
module tb_s_des_key_sched;

    logic       clk;
    logic       rst;
    logic       rv      [2];
    logic [9:0] key_v   [2];
    logic       dec_v   [2];
    logic       rdy     [2];
    logic [7:0] kf      [2];
    logic [7:0] ks      [2];
    logic       kv      [2];
    logic       busy_o  [2];

    int n_checks = 0;
    int n_pass   = 0;

    s_des_key_sched #(.OUT_PIPE(1'b0)) dut0 (
        .clk(clk), .rst(rst), .req_valid(rv[0]), .req_ready(rdy[0]),
        .key_in(key_v[0]), .decrypt(dec_v[0]), .k_first(kf[0]),
        .k_second(ks[0]), .keys_valid(kv[0]), .busy(busy_o[0])
    );

    s_des_key_sched #(.OUT_PIPE(1'b1)) dut1 (
        .clk(clk), .rst(rst), .req_valid(rv[1]), .req_ready(rdy[1]),
        .key_in(key_v[1]), .decrypt(dec_v[1]), .k_first(kf[1]),
        .k_second(ks[1]), .keys_valid(kv[1]), .busy(busy_o[1])
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue one request on instance sel (called at a negedge), then count
    // edges from the accepting edge until keys_valid and check the keys.
    task automatic request(input int sel, input logic [9:0] key, input logic dec,
                           input logic [7:0] ef, input logic [7:0] es,
                           input int lat, input string tag);
        int t;
        int edges;
        key_v[sel] = key;
        dec_v[sel] = dec;
        rv[sel]    = 1'b1;
        t = 0;
        while (!rdy[sel] && t < 20) begin
            @(negedge clk);
            t++;
        end
        check({tag, "_ready_timeout"}, (t < 20) ? 32'd1 : 32'd0, 32'd1);
        @(posedge clk);
        #1;
        rv[sel]    = 1'b0;
        key_v[sel] = ~key;   // must have no effect after accept
        dec_v[sel] = ~dec;
        check({tag, "_kv_drop"}, {31'd0, kv[sel]}, 32'd0);
        edges = 1;
        while (!kv[sel] && edges < 10) begin
            @(posedge clk);
            #1;
            edges++;
        end
        check({tag, "_latency"}, edges, lat);
        check({tag, "_k_first"}, {24'd0, kf[sel]}, {24'd0, ef});
        check({tag, "_k_second"}, {24'd0, ks[sel]}, {24'd0, es});
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            rv[i]    = 1'b0;
            key_v[i] = '0;
            dec_v[i] = 1'b0;
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("rst_kf%0d", i), {24'd0, kf[i]}, 32'd0);
            check($sformatf("rst_ks%0d", i), {24'd0, ks[i]}, 32'd0);
            check($sformatf("rst_kv%0d", i), {31'd0, kv[i]}, 32'd0);
            check($sformatf("rst_busy%0d", i), {31'd0, busy_o[i]}, 32'd0);
            check($sformatf("rst_ready%0d", i), {31'd0, rdy[i]}, 32'd1);
        end
        rst = 1'b0;
        @(negedge clk);

        // Scenarios 1-4, no output pipe
        request(0, 10'b1010000010, 1'b0, 8'b10100100, 8'b01000011, 3, "t1_enc");
        request(0, 10'b1010000010, 1'b1, 8'b01000011, 8'b10100100, 3, "t2_dec");
        request(0, 10'b0111111101, 1'b0, 8'b01011111, 8'b11111100, 3, "t3_enc");
        request(0, 10'h000, 1'b0, 8'h00, 8'h00, 3, "t4_zero");
        request(0, 10'h3FF, 1'b0, 8'hFF, 8'hFF, 3, "t4_ones");
        check("t4_hold_kv", {31'd0, kv[0]}, 32'd1);

        // Scenario 5: request held while busy is not taken until DONE
        key_v[0] = 10'b1010000010;
        dec_v[0] = 1'b0;
        rv[0]    = 1'b1;
        @(posedge clk);
        #1;
        key_v[0] = 10'b0111111101;   // held new request, still valid
        @(negedge clk);
        check("t5_ready_busy", {31'd0, rdy[0]}, 32'd0);
        check("t5_busy", {31'd0, busy_o[0]}, 32'd1);
        check("t5_prior_kf1", {24'd0, kf[0]}, 32'hFF);
        @(negedge clk);
        check("t5_prior_kf2", {24'd0, kf[0]}, 32'hFF);
        check("t5_prior_kv2", {31'd0, kv[0]}, 32'd0);
        @(negedge clk);
        check("t5_a_kv", {31'd0, kv[0]}, 32'd1);
        check("t5_a_kf", {24'd0, kf[0]}, 32'hA4);
        check("t5_a_ks", {24'd0, ks[0]}, 32'h43);
        @(posedge clk);
        #1;
        rv[0] = 1'b0;
        check("t5_b_accepted", {31'd0, busy_o[0]}, 32'd1);
        repeat (2) @(posedge clk);
        #1;
        check("t5_b_kv", {31'd0, kv[0]}, 32'd1);
        check("t5_b_kf", {24'd0, kf[0]}, 32'h5F);
        check("t5_b_ks", {24'd0, ks[0]}, 32'hFC);
        @(negedge clk);

        // Scenario 6: async reset during SHIFT2
        key_v[0] = 10'b1010000010;
        dec_v[0] = 1'b1;
        rv[0]    = 1'b1;
        @(posedge clk);
        #1;
        rv[0] = 1'b0;
        @(posedge clk);
        #1;
        check("t6_in_shift2", {31'd0, busy_o[0]}, 32'd1);
        rst = 1'b1;
        #1;
        check("t6_rst_kf", {24'd0, kf[0]}, 32'd0);
        check("t6_rst_ks", {24'd0, ks[0]}, 32'd0);
        check("t6_rst_kv", {31'd0, kv[0]}, 32'd0);
        check("t6_rst_busy", {31'd0, busy_o[0]}, 32'd0);
        check("t6_rst_ready", {31'd0, rdy[0]}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        request(0, 10'b0111111101, 1'b0, 8'b01011111, 8'b11111100, 3, "t6_after");

        // Scenarios 1-3 with the output pipe: one extra edge of latency
        request(1, 10'b1010000010, 1'b0, 8'b10100100, 8'b01000011, 4, "p1_enc");
        request(1, 10'b1010000010, 1'b1, 8'b01000011, 8'b10100100, 4, "p2_dec");
        request(1, 10'b0111111101, 1'b0, 8'b01011111, 8'b11111100, 4, "p3_enc");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Global watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
